// File: rtl/refund_dispenser_if.sv
// Refund dispenser bus: start/amount/status toward the shopping FSM and req/ack/sel toward the coin hopper.
interface refund_dispenser_if;
   logic       start;
   logic [7:0] amount;
   logic       clr_fault;
   logic       coin_ack;
   logic [2:0] empty;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] remaining;
   logic       coin_req;
   logic [1:0] coin_sel;

   modport slave (
      input  start, amount, clr_fault, coin_ack, empty,
      output busy, done, fault, remaining, coin_req, coin_sel
   );

   modport master (
      output start, amount, clr_fault, coin_ack, empty,
      input  busy, done, fault, remaining, coin_req, coin_sel
   );
endinterface

// File: rtl/refund_dispenser.sv
// Pays a refund as 10/5/1-yuan coins, largest first, skipping empty hoppers,
// via a four-phase req/ack hopper handshake; reports done or fault with the unpaid remainder.
module refund_dispenser #(
   parameter int unsigned ACK_TIMEOUT = 1000
) (
   input  logic               clk,
   input  logic               rst,
   refund_dispenser_if.slave  bus
);
   localparam int unsigned     CNT_W    = $clog2(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PICK, S_REQ, S_RELEASE, S_DONE, S_FAULT
   } state_t;

   state_t           r_state;
   logic [7:0]       r_remaining;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_fault;
   logic             r_coin_req;
   logic [1:0]       r_coin_sel;

   logic [1:0]       w_pick_sel;
   logic [7:0]       w_sel_value;

   // Largest coin that fits the remainder and whose hopper is not empty; 00 if none.
   always_comb begin
      w_pick_sel = 2'b00;
      if (!bus.empty[2] && (r_remaining >= 8'd10))
         w_pick_sel = 2'b11;
      else if (!bus.empty[1] && (r_remaining >= 8'd5))
         w_pick_sel = 2'b10;
      else if (!bus.empty[0] && (r_remaining >= 8'd1))
         w_pick_sel = 2'b01;
   end

   always_comb begin
      case (r_coin_sel)
         2'b01:   w_sel_value = 8'd1;
         2'b10:   w_sel_value = 8'd5;
         2'b11:   w_sel_value = 8'd10;
         default: w_sel_value = 8'd0;
      endcase
   end

   // Reset is asynchronous so coin_req drops at once, even mid-handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_remaining <= 8'd0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_coin_req  <= 1'b0;
         r_coin_sel  <= 2'b00;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_remaining <= bus.amount;
                  r_busy      <= 1'b1;
                  r_state     <= S_PICK;
               end
            end
            S_PICK: begin
               if (r_remaining == 8'd0) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_pick_sel != 2'b00) begin
                  r_coin_sel <= w_pick_sel;
                  r_coin_req <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= S_REQ;
               end else begin
                  r_fault <= 1'b1;
                  r_state <= S_FAULT;
               end
            end
            S_REQ: begin
               if (bus.coin_ack) begin
                  r_remaining <= r_remaining - w_sel_value;
                  r_coin_req  <= 1'b0;
                  r_coin_sel  <= 2'b00;
                  r_state     <= S_RELEASE;
               end else if (r_cnt == CNT_LAST) begin
                  r_coin_req <= 1'b0;
                  r_coin_sel <= 2'b00;
                  r_fault    <= 1'b1;
                  r_state    <= S_FAULT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (!bus.coin_ack)
                  r_state <= S_PICK;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_FAULT: begin
               if (bus.clr_fault) begin
                  r_fault     <= 1'b0;
                  r_busy      <= 1'b0;
                  r_remaining <= 8'd0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.fault     = r_fault;
   assign bus.remaining = r_remaining;
   assign bus.coin_req  = r_coin_req;
   assign bus.coin_sel  = r_coin_sel;
endmodule

// File: tb/tb_refund_dispenser.sv
// Self-checking bench for refund_dispenser: vector table, random refunds against a coin-change model,
// and directed timeout / async-reset sequences.
module tb_refund_dispenser;
   logic clk;
   logic rst;
   refund_dispenser_if bus();

   refund_dispenser #(.ACK_TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   int exp_sel_q[$];
   int exp_rem_q[$];
   bit exp_fault;
   int exp_final;

   int obs_sel_q[$];
   int obs_rem_q[$];
   bit obs_done;
   bit obs_fault;
   int obs_final;

   typedef struct {
      logic [7:0] amount;
      logic [2:0] empty;
      int         n_coins;
      bit         done;
      int         rem;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Greedy change-making from the refund rules, independent of any cycle timing.
   task automatic model(input int a, input logic [2:0] e);
      int rem;
      int d;
      exp_sel_q.delete();
      exp_rem_q.delete();
      exp_fault = 1'b0;
      rem = a;
      while (rem > 0) begin
         if (!e[2] && rem >= 10)     d = 10;
         else if (!e[1] && rem >= 5) d = 5;
         else if (!e[0])             d = 1;
         else                        d = 0;
         if (d == 0) begin
            exp_fault = 1'b1;
            break;
         end
         exp_sel_q.push_back(d == 10 ? 3 : (d == 5 ? 2 : 1));
         rem -= d;
         exp_rem_q.push_back(rem);
      end
      exp_final = rem;
   endtask

   // Runs one refund from IDLE (entered at a negedge) with a responsive hopper model.
   task automatic do_refund(input logic [7:0] a, input logic [2:0] e,
                            input int ack_dly, input int rel_dly);
      int n;
      int sel;
      int lim;
      model(int'(a), e);
      obs_sel_q.delete();
      obs_rem_q.delete();
      obs_done  = 1'b0;
      obs_fault = 1'b0;
      bus.start  = 1'b1;
      bus.amount = a;
      bus.empty  = e;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", int'(bus.busy), 1);
      chk("rem_after_start", int'(bus.remaining), int'(a));
      chk("req_after_start", int'(bus.coin_req), 0);
      @(negedge clk);
      chk("req_2cyc", int'(bus.coin_req), int'(exp_sel_q.size() > 0));
      chk("done_2cyc", int'(bus.done), int'(a == 8'd0));
      chk("fault_2cyc", int'(bus.fault), int'(exp_fault && exp_sel_q.size() == 0));
      n = 0;
      while (!obs_done && !obs_fault && n < 3000) begin
         if (bus.done) obs_done = 1'b1;
         else if (bus.fault) obs_fault = 1'b1;
         else begin
            if (bus.coin_req) begin
               sel = int'(bus.coin_sel);
               obs_sel_q.push_back(sel);
               repeat (ack_dly) begin
                  @(negedge clk); n++;
                  chk("req_held", int'(bus.coin_req), 1);
                  chk("sel_held", int'(bus.coin_sel), sel);
               end
               bus.coin_ack = 1'b1;
               @(negedge clk); n++;
               chk("req_drop_on_ack", int'(bus.coin_req), 0);
               obs_rem_q.push_back(int'(bus.remaining));
               repeat (rel_dly) begin
                  @(negedge clk); n++;
               end
               bus.coin_ack = 1'b0;
            end
            @(negedge clk); n++;
         end
      end
      if (n >= 3000) chk("run_bound_expired", 0, 1);
      obs_final = int'(bus.remaining);
      chk("n_coins", obs_sel_q.size(), exp_sel_q.size());
      lim = (obs_sel_q.size() < exp_sel_q.size()) ? obs_sel_q.size() : exp_sel_q.size();
      for (int i = 0; i < lim; i++) begin
         chk("coin_sel_seq", obs_sel_q[i], exp_sel_q[i]);
         chk("remaining_seq", obs_rem_q[i], exp_rem_q[i]);
      end
      chk("done_seen", int'(obs_done), int'(!exp_fault));
      chk("fault_seen", int'(obs_fault), int'(exp_fault));
      chk("final_rem", obs_final, exp_final);
      chk("req_low_end", int'(bus.coin_req), 0);
      if (obs_done) begin
         @(negedge clk);
         chk("done_one_cycle", int'(bus.done), 0);
         chk("busy_low_after_done", int'(bus.busy), 0);
      end
      if (obs_fault) begin
         bus.start  = 1'b1;
         bus.amount = 8'd99;
         @(negedge clk);
         bus.start = 1'b0;
         chk("fault_ignores_start", int'(bus.remaining), exp_final);
         chk("fault_held", int'(bus.fault), 1);
         bus.clr_fault = 1'b1;
         @(negedge clk);
         bus.clr_fault = 1'b0;
         chk("clr_fault_fault", int'(bus.fault), 0);
         chk("clr_fault_busy", int'(bus.busy), 0);
         chk("clr_fault_rem", int'(bus.remaining), 0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_fault"}, int'(bus.fault), 0);
      chk({tag, "_rem"}, int'(bus.remaining), 0);
      chk({tag, "_req"}, int'(bus.coin_req), 0);
      chk({tag, "_sel"}, int'(bus.coin_sel), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks = 0;
      errors = 0;
      tbl[0] = '{8'd17,  3'b000, 4,  1'b1, 0};
      tbl[1] = '{8'd0,   3'b000, 0,  1'b1, 0};
      tbl[2] = '{8'd12,  3'b100, 4,  1'b1, 0};
      tbl[3] = '{8'd3,   3'b001, 0,  1'b0, 3};
      tbl[4] = '{8'd255, 3'b000, 26, 1'b1, 0};
      tbl[5] = '{8'd9,   3'b110, 9,  1'b1, 0};
      tbl[6] = '{8'd7,   3'b011, 0,  1'b0, 7};
      tbl[7] = '{8'd16,  3'b101, 3,  1'b0, 1};
      tbl[8] = '{8'd4,   3'b000, 4,  1'b1, 0};

      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.amount    = 8'd0;
      bus.clr_fault = 1'b0;
      bus.coin_ack  = 1'b0;
      bus.empty     = 3'b000;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         do_refund(tbl[i].amount, tbl[i].empty, 0, 0);
         chk("tbl_coins", obs_sel_q.size(), tbl[i].n_coins);
         chk("tbl_done", int'(obs_done), int'(tbl[i].done));
         chk("tbl_rem", obs_final, tbl[i].rem);
      end

      for (int t = 0; t < 40; t++) begin
         logic [2:0] e;
         e = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         do_refund(8'($urandom_range(0, 255)), e,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Hopper never acks: 5-yuan request held for ACK_TIMEOUT cycles, then FAULT.
      bus.start  = 1'b1;
      bus.amount = 8'd6;
      bus.empty  = 3'b000;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      n = 0;
      while (bus.coin_req && bus.coin_sel == 2'b10 && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_req_cycles", n, 8);
      chk("timeout_fault", int'(bus.fault), 1);
      chk("timeout_req_low", int'(bus.coin_req), 0);
      chk("timeout_rem", int'(bus.remaining), 6);
      bus.clr_fault = 1'b1;
      @(negedge clk);
      bus.clr_fault = 1'b0;
      chk("timeout_clr_busy", int'(bus.busy), 0);

      // Reset asserted mid-handshake must drop coin_req before the next clock edge.
      bus.start  = 1'b1;
      bus.amount = 8'd20;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("pre_reset_req", int'(bus.coin_req), 1);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_refund(8'd5, 3'b000, 0, 0);
      chk("post_reset_coins", obs_sel_q.size(), 1);
      if (obs_sel_q.size() > 0) chk("post_reset_sel", obs_sel_q[0], 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/refund_dispenser.md
# refund_dispenser

Sequences physical change payout for the vending machine. When the shopping FSM finishes a cancel or purchase, it hands the refund amount to this block. The block breaks the amount into 10/5/1-yuan coins, largest first, skipping empty hoppers. It drives the coin hopper through a four-phase req/ack handshake and reports done, or fault with the unpaid remainder, to the shopping FSM and the numshow display path.

## Interface
- ACK_TIMEOUT, 1000: max cycles in REQ waiting for coin_ack rise before FAULT; must be ≥2.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  refund request; sampled only in IDLE.
- amount  in  8  refund in yuan, unsigned; latched on accepted start.
- clr_fault  in  1  leaves FAULT to IDLE.
- coin_ack  in  1  hopper acknowledge, four-phase.
- empty  in  3  hopper empty flags: bit0 = 1-yuan, bit1 = 5-yuan, bit2 = 10-yuan.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, refund fully paid.
- fault  out  1  high while in FAULT.
- remaining  out  8  yuan still owed.
- coin_req  out  1  hopper request, registered.
- coin_sel  out  2  00 none, 01 1-yuan, 10 5-yuan, 11 10-yuan; held stable while coin_req = 1.

## Operation
- States: IDLE, PICK, REQ, RELEASE, DONE, FAULT.
- Reset (rst = 0): state IDLE.
  - All outputs 0.
  - remaining = 0.
  - Timeout counter = 0.
  - coin_req drops immediately, asynchronously, even mid-handshake.
- IDLE:
  - On start = 1, load remaining ← amount and go to PICK.
  - start in any other state is ignored; it is not queued.
- PICK:
  - If remaining = 0, go to DONE.
  - Otherwise select the largest d in {10, 5, 1} with remaining ≥ d and its empty bit = 0.
    - Set coin_sel, set coin_req ← 1, clear the timeout counter, go to REQ.
  - If no d qualifies, go to FAULT.
  - empty is sampled only in PICK.
- REQ: hold coin_req and coin_sel.
  - On coin_ack = 1:
    - remaining ← remaining − value(coin_sel).
    - coin_req ← 0, coin_sel ← 00.
    - Go to RELEASE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT−1 without ack:
    - coin_req ← 0, coin_sel ← 00, go to FAULT.
    - remaining is not decremented.
- RELEASE: wait for coin_ack = 0, then go to PICK.
  - No timeout; the hopper must release.
- DONE:
  - done = 1 for this one cycle.
  - Go to IDLE.
- FAULT:
  - fault = 1; remaining holds the unpaid amount.
  - clr_fault = 1 leads to IDLE with remaining ← 0.
  - start is ignored in FAULT.
- Arithmetic: 8-bit unsigned. The subtraction cannot underflow because d ≤ remaining is checked in PICK.
- Coin values are 1, 5, 10. Maximum coins for amount 255: 25×10 + 1×5 = 26 requests.

## Timing
- start sampled high at edge k: busy = 1 and remaining = amount after edge k; PICK during cycle k+1.
- coin_req rises after edge k+1, i.e. 2 cycles after start.
- amount = 0: DONE after edge k+1; done high for one cycle, after edge k+1 until edge k+2; no coin_req ever.
- coin_ack sampled high at edge a: coin_req low and remaining updated after edge a.
- coin_ack sampled low in RELEASE at edge r: PICK during cycle r+1; next coin_req rises after edge r+1.
- Minimum per coin, with ack returned one cycle after req: 4 cycles (REQ, RELEASE, PICK, REQ...).
- done and the final remaining = 0 coexist in the DONE cycle.
- Return to IDLE occurs the edge after done.
- A new start is accepted in the first IDLE cycle.
- coin_ack already high when REQ is entered: accepted on the first REQ edge. The hopper contract requires ack low before req.
- Timeout: FAULT is entered exactly ACK_TIMEOUT edges after REQ entry with ack continuously low.

## Test plan
- amount = 17, empty = 000, hopper acks 1 cycle after req, releases 1 cycle after req drop -> coin_sel sequence 11, 10, 01, 01; remaining 17→7→2→1→0; one done pulse; busy low after.
- amount = 0 -> done pulse 2 cycles after start; coin_req never asserted; remaining = 0.
- amount = 12, empty = 100 -> coin_sel 10, 10, 01, 01; done.
- amount = 3, empty = 001 -> FAULT with remaining = 3 and no coin_req; clr_fault -> IDLE, remaining = 0.
- amount = 6, ACK_TIMEOUT = 8, hopper never acks -> coin_sel = 10 held 8 cycles, then FAULT, coin_req = 0, remaining = 6.
- amount = 20, rst pulled low while coin_req = 1 and ack pending -> coin_req low before the next clk edge; all outputs 0. After release, start with amount = 5 pays a single 10 code (5-yuan).
